// File: rtl/rr_arbiter_8.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rr_arbiter_8
//
// Eight-requester round-robin arbiter with a registered grant index.
// A grant is held until the owner pulses done, drops its request, or has
// held the grant for MAX_HOLD cycles (MAX_HOLD = 0 disables the limit).
// Every grant is followed by at least one idle cycle (gnt_valid = 0), so the
// downstream 3-to-8 decoder never switches select while its output is live.
//
// Parameters:
//   MAX_HOLD  maximum grant length in cycles, 0 = unlimited
//   CNT_W     hold counter width, MAX_HOLD must fit in 2^CNT_W-1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   request vector, bit k belongs to requester k
//   done       one-cycle release strobe from the current owner
//   gnt_idx    registered index of the current/last owner (decoder select)
//   gnt_valid  registered, high while gnt_idx names a live grant
//   timeout    registered one-cycle pulse on a hold-limit forced release
// ---------------------------------------------------------------------------
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last hold count value before the forced release fires.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam bit LIMIT_EN = (MAX_HOLD != 0);

    state_t           state_reg,   state_next;
    logic [2:0]       idx_reg,     idx_next;
    logic [2:0]       ptr_reg,     ptr_next;
    logic             valid_reg,   valid_next;
    logic             timeout_reg, timeout_next;
    logic [CNT_W-1:0] hold_reg,    hold_next;

    logic [7:0] rot_req;
    logic [2:0] rot_win;
    logic       any_req;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_limit;
    logic       release_now;

    // Rotate the request vector so that bit 0 is the requester at ptr.
    // The 3-bit add wraps, giving the mod-8 scan order for free.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + 3'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated vector = first requester at or after ptr.
    always_comb begin
        rot_win = '0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_win = 3'(i);
            end
        end
    end

    assign any_req = |req;

    assign rel_done    = done;
    assign rel_drop    = ~req[idx_reg];
    assign rel_limit   = LIMIT_EN && (hold_reg == HOLD_LAST);
    assign release_now = rel_done | rel_drop | rel_limit;

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        ptr_next     = ptr_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
        hold_next    = hold_reg;

        case (state_reg)
            IDLE: begin
                valid_next = 1'b0;
                if (any_req) begin
                    state_next = GRANT;
                    idx_next   = ptr_reg + rot_win;
                    valid_next = 1'b1;
                    hold_next  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_next   = IDLE;
                    valid_next   = 1'b0;
                    ptr_next     = idx_reg + 3'd1;
                    // Only flag a timeout when the limit alone ended the grant.
                    timeout_next = rel_limit & ~rel_done & ~rel_drop;
                end else if (hold_reg != '1) begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= 3'd0;
            ptr_reg     <= 3'd0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            hold_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            ptr_reg     <= ptr_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
            hold_reg    <= hold_next;
        end
    end

    assign gnt_idx   = idx_reg;
    assign gnt_valid = valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_8.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rr_arbiter_8
//
// Directed scenarios with literal expectations, followed by randomized
// req/done/reset traffic. A behavioural model tracks owner, pointer and the
// number of cycles the current grant has been visible, and a compare process
// checks every DUT output 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    rr_arbiter_8 #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // busy: a grant is live; vis: cycles the grant has been visible so far.
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_vis;
    bit         m_lim;
    bit         m_found;
    int         m_cand;
    logic [2:0] e_idx;
    bit         e_valid;
    bit         e_to;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_vis = 0;
            e_idx = 3'd0; e_valid = 0; e_to = 0;
        end else if (m_busy) begin
            m_lim = (MAX_HOLD != 0) && (m_vis == MAX_HOLD);
            if (done || !req[m_owner] || m_lim) begin
                m_busy  = 0;
                m_ptr   = (m_owner + 1) % 8;
                e_valid = 0;
                e_to    = m_lim && !done && req[m_owner];
            end else begin
                m_vis++;
                e_to = 0;
            end
        end else begin
            e_to    = 0;
            m_found = 0;
            for (int d = 0; d < 8; d++) begin
                m_cand = (m_ptr + d) % 8;
                if (!m_found && req[m_cand]) begin
                    m_found = 1;
                    m_owner = m_cand;
                end
            end
            if (m_found) begin
                m_busy  = 1;
                m_vis   = 1;
                e_idx   = 3'(m_owner);
                e_valid = 1;
            end
        end
        #1;
        check("model gnt_valid", 32'(gnt_valid), 32'(e_valid));
        check("model gnt_idx",   32'(gnt_idx),   32'(e_idx));
        check("model timeout",   32'(timeout),   32'(e_to));
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input bit v, input int idx, input bit to);
        check({name, " valid"},   32'(gnt_valid), 32'(v));
        if (v) check({name, " idx"}, 32'(gnt_idx), 32'(idx));
        check({name, " timeout"}, 32'(timeout),   32'(to));
    endtask

    task automatic reset_pulse(input logic [7:0] next_req);
        @(negedge clk);
        rst_n = 1'b0; req = 8'h00; done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; req = next_req;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; req = 8'h00; done = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset valid",   32'(gnt_valid), 32'd0);
        check("reset idx",     32'(gnt_idx),   32'd0);
        check("reset timeout", 32'(timeout),   32'd0);

        // Reset mid-grant: grant 5, then async reset, then regrant 5.
        @(negedge clk);
        rst_n = 1'b1; req = 8'h20;
        tick(); expect_out("first grant", 1, 5, 0);
        tick(); expect_out("hold grant", 1, 5, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rst valid",   32'(gnt_valid), 32'd0);
        check("async rst idx",     32'(gnt_idx),   32'd0);
        check("async rst timeout", 32'(timeout),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); expect_out("post rst grant", 1, 5, 0);
        @(negedge clk); req = 8'h00;
        tick(); expect_out("drop release", 0, 0, 0);

        // Single requester, done on the 3rd grant cycle, then regrant.
        @(negedge clk); req = 8'h04;
        tick(); expect_out("single c1", 1, 2, 0);
        tick(); expect_out("single c2", 1, 2, 0);
        tick(); expect_out("single c3", 1, 2, 0);
        @(negedge clk); done = 1'b1;
        tick(); expect_out("single idle", 0, 0, 0);
        check("single idx kept", 32'(gnt_idx), 32'd2);
        @(negedge clk); done = 1'b0;
        tick(); expect_out("single regrant", 1, 2, 0);
        @(negedge clk); req = 8'h00;
        tick(); expect_out("single drop", 0, 0, 0);

        // Round robin with all requesting, done every grant cycle.
        reset_pulse(8'hFF);
        for (int k = 0; k < 9; k++) begin
            tick(); expect_out($sformatf("rr grant %0d", k), 1, k % 8, 0);
            @(negedge clk); done = 1'b1;
            tick(); expect_out($sformatf("rr gap %0d", k), 0, 0, 0);
            @(negedge clk); done = 1'b0;
        end

        // Wrap and skip: serve 5, then req=0b11 -> 0, then 1.
        reset_pulse(8'h20);
        tick(); expect_out("wrap serve5", 1, 5, 0);
        @(negedge clk); done = 1'b1;
        tick(); expect_out("wrap rel5", 0, 0, 0);
        @(negedge clk); done = 1'b0; req = 8'b0000_0011;
        tick(); expect_out("wrap grant0", 1, 0, 0);
        @(negedge clk); done = 1'b1;
        tick(); expect_out("wrap rel0", 0, 0, 0);
        @(negedge clk); done = 1'b0;
        tick(); expect_out("wrap grant1", 1, 1, 0);
        @(negedge clk); req = 8'h00;
        tick(); expect_out("wrap rel1", 0, 0, 0);

        // Timeout: requester 7 holds for exactly MAX_HOLD cycles.
        reset_pulse(8'h80);
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick(); expect_out($sformatf("to hold %0d", c), 1, 7, 0);
        end
        tick(); expect_out("to pulse", 0, 0, 1);
        check("to idx kept", 32'(gnt_idx), 32'd7);
        tick(); expect_out("to regrant", 1, 7, 0);
        // done coincides with the limit: release without timeout.
        tick(); expect_out("sim c2", 1, 7, 0);
        tick(); expect_out("sim c3", 1, 7, 0);
        tick(); expect_out("sim c4", 1, 7, 0);
        @(negedge clk); done = 1'b1;
        tick(); expect_out("sim done+limit", 0, 0, 0);
        @(negedge clk); done = 1'b0;
        tick(); expect_out("drop regrant", 1, 7, 0);
        @(negedge clk); req = 8'h00;
        tick(); expect_out("drop release", 0, 0, 0);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
            end
            case ($urandom_range(0, 2))
                0:       req = 8'($urandom);
                1:       req = 8'($urandom & $urandom & $urandom);
                default: req = (8'd1 << $urandom_range(0, 7));
            endcase
            done = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        rst_n = 1'b1; req = 8'h00; done = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
